// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues rd_en, captures dout into a 2-entry buffer,
// presents a valid/ready stream with optional m_last framing. FIFO read to m_valid is 2 cycles.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  en,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            buf_cnt,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  logic                  pop;
  logic [2:0]            occ;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  at_last;

  assign pop     = m_valid & m_ready;
  // Occupancy counts the in-flight word so a read is only issued when a slot is guaranteed.
  assign occ     = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign fifo_rd_en = en & ~fifo_empty & ~sclr & (occ < (3'd2 + {2'b00, pop}));

  assign eff_len = (beat_q == '0) ? cfg_pkt_len : len_q;
  assign at_last = (eff_len != '0) && (beat_q == (eff_len - LEN_ONE));

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = mem_q[head_q];
  assign m_last  = m_valid & at_last;
  assign buf_cnt = cnt_q;
  assign busy    = (cnt_q != 2'd0) | inflight_q;

  always_comb begin
    cnt_d  = cnt_q;
    case ({inflight_q, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    head_d = pop ? ~head_q : head_q;
    tail_d = inflight_q ? ~tail_q : tail_q;
    beat_d = beat_q;
    len_d  = len_q;
    if (pop && (eff_len != '0)) begin
      beat_d = at_last ? '0 : (beat_q + LEN_ONE);
      if (beat_q == '0) begin
        len_d = cfg_pkt_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      len_q      <= '0;
    end else begin
      if (inflight_q) begin
        mem_q[tail_q] <= fifo_dout;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, stream scoreboard with packet model, directed and random runs.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          sclr, en, fifo_empty, fifo_rd_en, m_valid, m_ready, m_last, busy;
  logic [LW-1:0] cfg_pkt_len;
  logic [DW-1:0] fifo_dout, m_data;
  logic [1:0]    buf_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .sclr(sclr), .en(en), .cfg_pkt_len(cfg_pkt_len),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .buf_cnt(buf_cnt), .busy(busy)
  );

  typedef struct {
    int n;
    int len;
    int rdy_pct;
    int exp_lasts;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_n = 0;
  int pkt_left = 0;
  logic [DW-1:0] fq [$];
  logic [DW-1:0] exp_q [$];
  int rd_log [$];
  int pop_log [$];
  int last_log [$];
  logic hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    pop_log.delete();
    last_log.delete();
    pop_n = 0;
  endtask

  // Scoreboard sampled at the falling edge.
  task automatic monitor();
    logic [DW-1:0] exp_d;
    logic exp_last;
    if (sclr) begin
      chk("rd_en_in_reset", fifo_rd_en, 0);
      pkt_left = 0;
      hold = 1'b0;
    end else begin
      chk("valid_vs_cnt", m_valid, (buf_cnt != 2'd0));
      if (hold && m_valid) begin
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (fifo_rd_en) rd_log.push_back(cyc);
      if (m_valid && m_ready) begin
        pop_n++;
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat (cycle %0d)", m_data, cyc);
        end else begin
          exp_d = exp_q.pop_front();
          chk("data", m_data, exp_d);
          if (pkt_left == 0) pkt_left = int'(cfg_pkt_len);
          exp_last = (pkt_left == 1);
          if (pkt_left > 0) pkt_left--;
          chk("last", m_last, exp_last);
        end
        if (m_last) last_log.push_back(pop_n);
      end
      hold = m_valid & ~m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  endtask

  // One cycle: monitor at negedge, FIFO model updates just after posedge.
  task automatic tick();
    logic rd, rst;
    @(negedge clk);
    monitor();
    rd  = fifo_rd_en & ~fifo_empty;
    rst = sclr;
    @(posedge clk);
    #1;
    if (rst) begin
      fq.delete();
      fifo_empty = 1'b1;
      fifo_dout  = '0;
    end else if (rd) begin
      fifo_dout  = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    cyc++;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    en   = 1'b0;
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cnt", buf_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", m_last, 0);
    sclr = 1'b0;
    exp_q.delete();
    clear_logs();
  endtask

  task automatic wait_drain(input string name, input int budget, input int rdy_pct, input int en_pct);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      if (rdy_pct >= 0) m_ready = ($urandom_range(99) < rdy_pct);
      if (en_pct >= 0)  en      = ($urandom_range(99) < en_pct);
      tick();
      b--;
    end
    chk({"drain_", name}, exp_q.size(), 0);
  endtask

  initial begin
    vec_t tbl [6];
    int n, len, pct, enp;
    int exp_last_list [4];

    sclr = 1'b1; en = 1'b0; m_ready = 1'b0; cfg_pkt_len = '0;
    fifo_empty = 1'b1; fifo_dout = '0;

    // Reset / idle
    repeat (2) begin
      tick();
      chk("idle_valid", m_valid, 0);
      chk("idle_data", m_data, 0);
      chk("idle_rd_en", fifo_rd_en, 0);
      chk("idle_cnt", buf_cnt, 0);
      chk("idle_busy", busy, 0);
    end
    sclr = 1'b0;
    en = 1'b1;
    tick();
    chk("idle_empty_rd_en", fifo_rd_en, 0);
    chk("idle_empty_valid", m_valid, 0);

    // Streaming at full rate
    do_reset();
    cfg_pkt_len = '0;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    en = 1'b1;
    wait_drain("stream", 40, -1, -1);
    repeat (2) tick();
    chk("stream_reads", rd_log.size(), 8);
    chk("stream_pops", pop_log.size(), 8);
    if (rd_log.size() == 8 && pop_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("stream_rd_cycle", rd_log[i], rd_log[0] + i);
        chk("stream_pop_cycle", pop_log[i], rd_log[0] + 2 + i);
      end
    end
    chk("stream_lasts", last_log.size(), 0);

    // Backpressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    en = 1'b1;
    repeat (6) tick();
    chk("bp_reads", rd_log.size(), 2);
    chk("bp_cnt", buf_cnt, 2);
    chk("bp_data", m_data, 8'h01);
    chk("bp_valid", m_valid, 1);
    chk("bp_fifo_left", fq.size(), 6);
    m_ready = 1'b1;
    wait_drain("bp", 40, -1, -1);
    repeat (3) tick();
    chk("bp_reads_total", rd_log.size(), 8);
    chk("bp_pops_total", pop_log.size(), 8);
    chk("bp_cnt_end", buf_cnt, 0);
    chk("bp_busy_end", busy, 0);

    // Framing with a length change mid-packet
    do_reset();
    cfg_pkt_len = 8'd3;
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(DW'(8'h10 + i));
    en = 1'b1;
    for (int b = 0; b < 30 && pop_n < 4; b++) tick();
    chk("frm_reached_beat4", pop_n >= 4, 1);
    cfg_pkt_len = 8'd2;
    for (int i = 7; i < 10; i++) push(DW'(8'h10 + i));
    wait_drain("frame", 40, -1, -1);
    repeat (2) tick();
    exp_last_list[0] = 3; exp_last_list[1] = 6; exp_last_list[2] = 8; exp_last_list[3] = 10;
    chk("frm_last_count", last_log.size(), 4);
    if (last_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("frm_last_beat", last_log[i], exp_last_list[i]);

    // en deasserted right after one read
    do_reset();
    cfg_pkt_len = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(8'h20 + i));
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (3) tick();
    chk("en_reads", rd_log.size(), 1);
    chk("en_cnt", buf_cnt, 1);
    m_ready = 1'b1;
    repeat (4) tick();
    chk("en_pops", pop_log.size(), 1);
    chk("en_cnt_end", buf_cnt, 0);
    chk("en_busy_end", busy, 0);
    chk("en_rd_en_end", fifo_rd_en, 0);
    chk("en_fifo_left", fq.size(), 3);

    // Reset in the middle of a packet with data buffered and in flight
    do_reset();
    cfg_pkt_len = 8'd2;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(DW'(8'h30 + i));
    en = 1'b1;
    for (int b = 0; b < 20 && pop_n < 1; b++) tick();
    m_ready = 1'b0;
    tick();
    chk("mid_pre_busy", busy, 1);
    sclr = 1'b1;
    tick();
    chk("mid_valid", m_valid, 0);
    chk("mid_cnt", buf_cnt, 0);
    chk("mid_busy", busy, 0);
    chk("mid_last", m_last, 0);
    sclr = 1'b0;
    exp_q.delete();
    clear_logs();
    m_ready = 1'b1;
    repeat (5) tick();
    chk("mid_no_stale", pop_log.size(), 0);
    chk("mid_valid_after", m_valid, 0);
    push(8'h40);
    push(8'h41);
    wait_drain("mid", 20, -1, -1);
    chk("mid_last_count", last_log.size(), 1);
    if (last_log.size() == 1) chk("mid_last_beat", last_log[0], 2);

    // Table-driven scenarios
    tbl[0] = '{n: 8,  len: 0, rdy_pct: 100, exp_lasts: 0};
    tbl[1] = '{n: 7,  len: 3, rdy_pct: 70,  exp_lasts: 2};
    tbl[2] = '{n: 6,  len: 1, rdy_pct: 50,  exp_lasts: 6};
    tbl[3] = '{n: 9,  len: 4, rdy_pct: 30,  exp_lasts: 2};
    tbl[4] = '{n: 12, len: 5, rdy_pct: 80,  exp_lasts: 2};
    tbl[5] = '{n: 4,  len: 4, rdy_pct: 60,  exp_lasts: 1};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      cfg_pkt_len = LW'(tbl[t].len);
      for (int i = 0; i < tbl[t].n; i++) push(DW'($urandom_range(255)));
      en = 1'b1;
      wait_drain("tbl", 400, tbl[t].rdy_pct, 100);
      m_ready = 1'b1;
      repeat (3) tick();
      chk("tbl_pops", pop_n, tbl[t].n);
      chk("tbl_lasts", last_log.size(), tbl[t].exp_lasts);
      chk("tbl_busy", busy, 0);
    end

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      n   = $urandom_range(20, 1);
      len = $urandom_range(4, 0);
      pct = $urandom_range(100, 20);
      enp = $urandom_range(100, 50);
      do_reset();
      cfg_pkt_len = LW'(len);
      for (int i = 0; i < n; i++) push(DW'($urandom_range(255)));
      wait_drain("rand", 600, pct, enp);
      en = 1'b1;
      m_ready = 1'b1;
      repeat (3) tick();
      chk("rand_pops", pop_n, n);
      chk("rand_lasts", last_log.size(), (len != 0) ? n / len : 0);
      chk("rand_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
